// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, registered sync/blank decode, frame counter.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by SYNC_DELAY pixel-enable cycles.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic       wrap;
  logic       hs_r, vs_r;

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    wrap  = 1'b0;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt = '0;
        wrap  = 1'b1;
      end else begin
        v_nxt = v_cnt + 10'd1;
      end
    end
  end

  // Decode from next-state counts so sync/blank line up with DrawX/DrawY.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      blank       <= 1'b1;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (pix_ce) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      blank       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hs_r        <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vs_r        <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
      frame_start <= wrap;
      if (wrap) frame_count <= frame_count + 8'd1;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign DrawX = h_cnt;
  assign DrawY = v_cnt;

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else if (pix_ce) begin
      hs_pipe[0] <= hs_r;
      vs_pipe[0] <= vs_r;
      for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hs = hs_pipe[SYNC_DELAY-1];
  assign vs = vs_pipe[SYNC_DELAY-1];
`else
  logic unused_sync_delay;
  assign unused_sync_delay = ^32'(SYNC_DELAY);
  assign hs = hs_r;
  assign vs = vs_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-geometry instance for line timing, reduced-geometry instance for
// frame-level behaviour (frame pulse, vs, pix_ce gating, frame_count wrap).
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  // Reduced geometry: H 8+2+4+2 = 16, V 6+1+2+1 = 10, frame = 160 pixels.
  localparam int SH = 16;
  localparam int SV = 10;
  localparam int SF = SH * SV;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       pix_ce;
  logic [9:0] dx, dy, sx, sy;
  logic       d_blank, d_hs, d_vs, d_fs, s_blank, s_hs, s_vs, s_fs;
  logic [7:0] d_fc, s_fc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .DrawX(dx), .DrawY(dy), .blank(d_blank), .hs(d_hs), .vs(d_vs),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_DELAY(2)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .DrawX(sx), .DrawY(sy), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    int unsigned h;
    logic        hs_nd;
    logic        hs_d;
    logic        blank;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    pix_ce  = 1'b1;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  // Expected small-instance outputs after p pixel advances since reset.
  task automatic check_small(input string tag, input int p, input logic fs_exp);
    int h, v, q;
    logic hs_e, vs_e;
    h = p % SH;
    v = (p / SH) % SV;
    q = p - D;
    if (q < 0) begin
      hs_e = 1'b1;
      vs_e = 1'b1;
    end else begin
      hs_e = !(((q % SH) >= 10) && ((q % SH) < 14));
      vs_e = !((((q / SH) % SV) >= 7) && (((q / SH) % SV) < 9));
    end
    chk({tag, ".x"},  32'(sx), 32'(h));
    chk({tag, ".y"},  32'(sy), 32'(v));
    chk({tag, ".blank"}, 32'(s_blank), 32'((h < 8) && (v < 6)));
    chk({tag, ".hs"}, 32'(s_hs), 32'(hs_e));
    chk({tag, ".vs"}, 32'(s_vs), 32'(vs_e));
    chk({tag, ".fs"}, 32'(s_fs), 32'(fs_exp));
    chk({tag, ".fc"}, 32'(s_fc), 32'((p / SF) % 256));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".dx"},    32'(dx), 0);
    chk({tag, ".dy"},    32'(dy), 0);
    chk({tag, ".blank"}, 32'(d_blank), 1);
    chk({tag, ".hs"},    32'(d_hs), 1);
    chk({tag, ".vs"},    32'(d_vs), 1);
    chk({tag, ".fs"},    32'(d_fs), 0);
    chk({tag, ".fc"},    32'(d_fc), 0);
    chk({tag, ".sfc"},   32'(s_fc), 0);
    chk({tag, ".sx"},    32'(sx), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int p;

    //           h    hs   hs+2 blank
    tbl = '{ '{  0, 1'b1, 1'b1, 1'b1},
             '{639, 1'b1, 1'b1, 1'b1},
             '{640, 1'b1, 1'b1, 1'b0},
             '{655, 1'b1, 1'b1, 1'b0},
             '{656, 1'b0, 1'b1, 1'b0},
             '{657, 1'b0, 1'b1, 1'b0},
             '{658, 1'b0, 1'b0, 1'b0},
             '{751, 1'b0, 1'b0, 1'b0},
             '{752, 1'b1, 1'b0, 1'b0},
             '{753, 1'b1, 1'b0, 1'b0},
             '{754, 1'b1, 1'b1, 1'b0},
             '{799, 1'b1, 1'b1, 1'b0} };

    // Reset values while reset is held
    reset_n = 1'b0;
    pix_ce  = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset_state("rst");

    // First line with default geometry
    do_reset;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].h - cur) tick;
      cur = tbl[i].h;
      chk($sformatf("line.x@%0d", tbl[i].h), 32'(dx), tbl[i].h);
      chk($sformatf("line.y@%0d", tbl[i].h), 32'(dy), 0);
      chk($sformatf("line.hs@%0d", tbl[i].h), 32'(d_hs), 32'((D != 0) ? tbl[i].hs_d : tbl[i].hs_nd));
      chk($sformatf("line.blank@%0d", tbl[i].h), 32'(d_blank), 32'(tbl[i].blank));
      chk($sformatf("line.fs@%0d", tbl[i].h), 32'(d_fs), 0);
    end
    tick;
    chk("line.wrap_x", 32'(dx), 0);
    chk("line.wrap_y", 32'(dy), 1);
    chk("line.wrap_fs", 32'(d_fs), 0);

    // Full reduced frame, every pixel
    do_reset;
    for (int c = 1; c <= SF + 2; c++) begin
      tick;
      check_small("frame", c, c == SF);
    end

    // pix_ce alternating 1,0: counters advance every other clock
    do_reset;
    p = 0;
    for (int k = 1; k <= 1600; k++) begin
      pix_ce = (k % 2 == 1);
      tick;
      if (pix_ce) p++;
      check_small("ce", p, pix_ce && (p % SF == 0) && (p > 0));
      chk("ce.dx", 32'(dx), 32'(p % 800));
      chk("ce.dy", 32'(dy), 32'(p / 800));
    end
    pix_ce = 1'b1;

    // Asynchronous reset mid-line, mid-frame
    do_reset;
    repeat (700) tick;
    chk("mid.dx", 32'(dx), 700);
    chk("mid.hs", 32'(d_hs), 0);
    chk("mid.sfc", 32'(s_fc), 4);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async");

    // 256 reduced frames: frame_count wraps 255 -> 0
    do_reset;
    for (int f = 1; f <= 256; f++) begin
      tick;
      chk("wrap.fs_clear", 32'(s_fs), 0);
      repeat (SF - 2) tick;
      chk("wrap.fc_before", 32'(s_fc), 32'((f - 1) % 256));
      chk("wrap.fs_before", 32'(s_fs), 0);
      tick;
      chk("wrap.fs", 32'(s_fs), 1);
      chk("wrap.fc", 32'(s_fc), 32'(f % 256));
      chk("wrap.x0", 32'(sx), 0);
      chk("wrap.y0", 32'(sy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
